key_event_dispatcher: RTL and testbench
=======================================

Name: key_event_dispatcher

Overview:
- Sits between the PS/2 keyboard decoder and the game logic of the red-light/green-light game.
- Filters decoded key events down to the four player move keys and buffers make events in a small FIFO.
- Dispatches buffered events one at a time to the owning player's valid/ready port.
- Raises a foul pulse when a player presses a move key while the game is frozen ("red light").

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- P1_KEY_A, 9'h01C, extended-flag plus scan code for player 1 move A.
- P1_KEY_B, 9'h023, player 1 move B.
- P2_KEY_A, 9'h16B, player 2 move A.
- P2_KEY_B, 9'h174, player 2 move B.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- key_valid  in  1  one-cycle pulse from the decoder: a key event occurred.
- last_change  in  9  {extend, scan code} of the event.
- key_down  in  512  key-state vector, already updated in the key_valid cycle.
- freeze  in  1  1 = red light (no movement allowed).
- p1_evt_valid  out  1  player 1 event available.
- p1_evt_key  out  1  0 = move A, 1 = move B.
- p1_evt_ready  in  1  player 1 consumer accepts.
- p2_evt_valid, p2_evt_key, p2_evt_ready  as for player 1.
- p1_foul, p2_foul  out  1  one-cycle foul pulses.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO emptied; fifo_count = 0.
  - All valid outputs, evt_key outputs, foul outputs and overflow = 0.
  - FSM returns to IDLE.
- Classification, in a cycle with key_valid = 1:
  - make = key_down[last_change].
  - Break events (make = 0) are ignored.
  - Codes matching none of the four parameters are ignored.
  - A matching make event yields {player, sel}.
- With freeze = 1 in that cycle: the event is not enqueued, and the owning player's foul output pulses high for exactly one cycle, starting the next cycle.
- With freeze = 0: the event is written at the end of the cycle.
  - Full is evaluated before any same-cycle pop, so a push into a full FIFO is dropped and overflow is set.
  - overflow clears only on reset.
- Flush: on a 0→1 edge of freeze (previous-cycle register), the FIFO is flushed and both evt_valid outputs drop the following cycle.
  - Any event presented on an output is discarded, even if ready was high that cycle.
  - The flush has priority over a simultaneous push; that push is a foul case anyway because freeze = 1.
- FSM states and transitions:
  - IDLE → LOAD when the FIFO is non-empty: pop the head into the output register and assert the owning player's evt_valid. The other player's valid stays 0.
  - PRESENT holds evt_valid and evt_key stable until the matching ready is high at a clock edge. Ready on the non-owning port has no effect (head-of-line blocking is intentional; order is preserved across players).
  - On a transfer edge: if the FIFO is non-empty, the next head is loaded at that same edge, giving back-to-back throughput of 1 event/cycle. Otherwise the FSM goes to IDLE and valid drops.
  - Flush from any state → IDLE.
- Latency: key_valid in cycle T → fifo_count = 1 in T+1 → evt_valid high in T+2.
- fifo_count excludes the event held in the output register.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from count.
- Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.

Test Plan:
- freeze = 0; key_valid with last_change = 9'h01C and key_down[9'h01C] = 1 at T → p1_evt_valid = 1 and p1_evt_key = 0 at T+2; p2_evt_valid = 0; p1_evt_ready = 1 → valid drops at T+3.
- Break event for 9'h174 (key_down bit 0), then unmapped make 9'h029 → no valid, no foul, fifo_count stays 0.
- freeze = 1; make 9'h16B → p2_foul high exactly one cycle at T+1; fifo_count = 0; p2_evt_valid never asserts.
- Both ready = 0; issue 10 make events for 9'h023 → first in the output register, 8 in the FIFO (fifo_count = 8), last one dropped, overflow = 1. Then p1_evt_ready = 1 → p1_evt_valid stays high for 9 consecutive cycles with one transfer each cycle, then drops.
- Queue interleaved P1 and P2 events with p2_evt_ready held 1 → P2 events wait behind the P1 head until p1_evt_ready; delivery order matches issue order.
- 3 events queued, then freeze 0→1 → next cycle fifo_count = 0 and both valids = 0. Separately, assert rst mid-PRESENT → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/key_event_dispatcher.sv
// key_event_dispatcher: filters decoded PS/2 key events down to the four player
// move keys, buffers make events in a FIFO and hands them out one at a time on
// the owning player's valid/ready port. Flags fouls made during red light.
module key_event_dispatcher #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [8:0]  P1_KEY_A = 9'h01C,
    parameter logic [8:0]  P1_KEY_B = 9'h023,
    parameter logic [8:0]  P2_KEY_A = 9'h16B,
    parameter logic [8:0]  P2_KEY_B = 9'h174
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [8:0]               last_change,
    input  logic [511:0]             key_down,
    input  logic                     freeze,
    output logic                     p1_evt_valid,
    output logic                     p1_evt_key,
    input  logic                     p1_evt_ready,
    output logic                     p2_evt_valid,
    output logic                     p2_evt_key,
    input  logic                     p2_evt_ready,
    output logic                     p1_foul,
    output logic                     p2_foul,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // LOAD is the first cycle an event is presented, PRESENT any later cycle.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            freeze_q;
    logic [1:0]      mem [DEPTH];   // {player, sel}; player 0 = P1, 1 = P2
    logic [1:0]      head;

    logic            is_make;
    logic            match;
    logic            hit_player;
    logic            hit_sel;
    logic            hit;
    logic            push;
    logic            full;
    logic            push_ok;
    logic            flush;
    logic            xfer;
    logic            pop;

    // Map the event code onto one of the four move keys.
    always_comb begin
        match      = 1'b1;
        hit_player = 1'b0;
        hit_sel    = 1'b0;
        if (last_change == P1_KEY_A) begin
            hit_player = 1'b0;
            hit_sel    = 1'b0;
        end else if (last_change == P1_KEY_B) begin
            hit_player = 1'b0;
            hit_sel    = 1'b1;
        end else if (last_change == P2_KEY_A) begin
            hit_player = 1'b1;
            hit_sel    = 1'b0;
        end else if (last_change == P2_KEY_B) begin
            hit_player = 1'b1;
            hit_sel    = 1'b1;
        end else begin
            match = 1'b0;
        end
    end

    // Handshake and FIFO control; full is judged on the pre-pop occupancy.
    always_comb begin
        is_make = key_down[last_change];
        hit     = key_valid & is_make & match;
        push    = hit & ~freeze;
        full    = (fifo_count == CW'(DEPTH));
        push_ok = push & ~full;
        flush   = freeze & ~freeze_q;
        xfer    = (p1_evt_valid & p1_evt_ready) | (p2_evt_valid & p2_evt_ready);
        pop     = ~flush & (fifo_count != '0) & ((state == IDLE) | xfer);
        head    = mem[rd_ptr];
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {hit_player, hit_sel};
        end
    end

    // Pointers, occupancy, fouls, overflow and the dispatch FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            freeze_q     <= 1'b0;
            p1_evt_valid <= 1'b0;
            p1_evt_key   <= 1'b0;
            p2_evt_valid <= 1'b0;
            p2_evt_key   <= 1'b0;
            p1_foul      <= 1'b0;
            p2_foul      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            freeze_q <= freeze;
            p1_foul  <= hit & freeze & ~hit_player;
            p2_foul  <= hit & freeze & hit_player;
            if (push & full) begin
                overflow <= 1'b1;
            end

            if (flush) begin
                // Red light just started: discard everything pending.
                state        <= IDLE;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                fifo_count   <= '0;
                p1_evt_valid <= 1'b0;
                p2_evt_valid <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);

                if (pop) begin
                    p1_evt_valid <= ~head[1];
                    p2_evt_valid <= head[1];
                    if (head[1]) begin
                        p2_evt_key <= head[0];
                    end else begin
                        p1_evt_key <= head[0];
                    end
                end

                case (state)
                    IDLE: begin
                        if (pop) begin
                            state <= LOAD;
                        end
                    end
                    LOAD, PRESENT: begin
                        if (xfer) begin
                            if (pop) begin
                                state <= LOAD;
                            end else begin
                                state        <= IDLE;
                                p1_evt_valid <= 1'b0;
                                p2_evt_valid <= 1'b0;
                            end
                        end else begin
                            state <= PRESENT;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        p1_evt_valid <= 1'b0;
                        p2_evt_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_dispatcher.sv
// Bench for key_event_dispatcher: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_key_event_dispatcher;

    localparam int DEPTH = 8;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         freeze;
    logic         p1_evt_valid, p1_evt_key, p1_evt_ready;
    logic         p2_evt_valid, p2_evt_key, p2_evt_ready;
    logic         p1_foul, p2_foul, overflow;
    logic [3:0]   fifo_count;

    key_event_dispatcher #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .last_change  (last_change),
        .key_down     (key_down),
        .freeze       (freeze),
        .p1_evt_valid (p1_evt_valid),
        .p1_evt_key   (p1_evt_key),
        .p1_evt_ready (p1_evt_ready),
        .p2_evt_valid (p2_evt_valid),
        .p2_evt_key   (p2_evt_key),
        .p2_evt_ready (p2_evt_ready),
        .p1_foul      (p1_foul),
        .p2_foul      (p2_foul),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue of pending events plus one presented slot.
    int q[$];
    bit m_sv;       // slot holds an event
    int m_sp;       // slot owner, 0 = P1, 1 = P2
    int m_sk;       // slot key select
    bit m_ovf, m_f1, m_f2, m_fp;

    // Transfers seen on the ports, recorded as player*2+sel.
    int deliv[$];
    always @(posedge clk) begin
        if (!rst) begin
            if (p1_evt_valid && p1_evt_ready) deliv.push_back(int'(p1_evt_key));
            if (p2_evt_valid && p2_evt_ready) deliv.push_back(2 + int'(p2_evt_key));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int code_id(input logic [8:0] c);
        case (c)
            9'h01C:  return 0;
            9'h023:  return 1;
            9'h16B:  return 2;
            9'h174:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_sv = 0; m_sp = 0; m_sk = 0;
        m_ovf = 0; m_f1 = 0; m_f2 = 0; m_fp = 0;
    endtask

    task automatic model_step(input bit make, input logic [8:0] code, input bit frz,
                              input bit r1, input bit r2);
        int  id;
        bit  ev, xfer;
        int  n, e;
        id   = code_id(code);
        ev   = make && (id >= 0);
        m_f1 = ev && frz && (id < 2);
        m_f2 = ev && frz && (id >= 2);
        if (frz && !m_fp) begin
            q.delete();
            m_sv = 0;
        end else begin
            xfer = m_sv && ((m_sp == 0) ? r1 : r2);
            n    = q.size();
            if (!m_sv || xfer) begin
                if (n > 0) begin
                    e    = q.pop_front();
                    m_sv = 1;
                    m_sp = e / 2;
                    m_sk = e % 2;
                end else begin
                    m_sv = 0;
                end
            end
            if (ev && !frz) begin
                if (n == DEPTH) m_ovf = 1;
                else            q.push_back(id);
            end
        end
        m_fp = frz;
    endtask

    task automatic compare_model();
        chk("p1_valid", p1_evt_valid, m_sv && m_sp == 0);
        chk("p2_valid", p2_evt_valid, m_sv && m_sp == 1);
        if (m_sv && m_sp == 0) chk("p1_key", p1_evt_key, m_sk);
        if (m_sv && m_sp == 1) chk("p2_key", p2_evt_key, m_sk);
        chk("p1_foul", p1_foul, m_f1);
        chk("p2_foul", p2_foul, m_f2);
        chk("overflow", overflow, m_ovf);
        chk("fifo_count", fifo_count, q.size());
    endtask

    // One clock: drive inputs, step the model at the edge, check just after.
    task automatic cycle(input bit kv, input logic [8:0] code, input bit dn,
                         input bit frz, input bit r1, input bit r2);
        key_valid   = kv;
        last_change = code;
        for (int w = 0; w < 16; w++) key_down[w*32 +: 32] = $urandom();
        key_down[code] = dn;
        freeze       = frz;
        p1_evt_ready = r1;
        p2_evt_ready = r2;
        @(posedge clk);
        model_step(kv && dn, code, frz, r1, r2);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit         kv;
        logic [8:0] code;
        bit         dn, frz, r1, r2;
        bit         p1v, p1k, p2v, p2k, f1, f2, ovf;
        int         cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int exp_order[4];
        tbl[0]  = '{1, 9'h01C, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 9'h000, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 9'h000, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 9'h174, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 9'h029, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 9'h16B, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 9'h000, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 9'h023, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{0, 9'h000, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 9'h174, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 9'h000, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0};
        tbl[11] = '{0, 9'h000, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0};
        tbl[12] = '{0, 9'h000, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        key_valid = 0; last_change = '0; key_down = '0; freeze = 0;
        p1_evt_ready = 0; p2_evt_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p1_valid", p1_evt_valid, 0);
        chk("rst_p2_valid", p2_evt_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].kv, tbl[i].code, tbl[i].dn, tbl[i].frz, tbl[i].r1, tbl[i].r2);
            chk($sformatf("tbl%0d_p1v", i), p1_evt_valid, tbl[i].p1v);
            chk($sformatf("tbl%0d_p2v", i), p2_evt_valid, tbl[i].p2v);
            if (tbl[i].p1v) chk($sformatf("tbl%0d_p1k", i), p1_evt_key, tbl[i].p1k);
            if (tbl[i].p2v) chk($sformatf("tbl%0d_p2k", i), p2_evt_key, tbl[i].p2k);
            chk($sformatf("tbl%0d_f1", i), p1_foul, tbl[i].f1);
            chk($sformatf("tbl%0d_f2", i), p2_foul, tbl[i].f2);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
            chk($sformatf("tbl%0d_cnt", i), fifo_count, tbl[i].cnt);
        end

        // Ten makes with nobody ready: one presented, eight queued, one dropped.
        for (int i = 0; i < 10; i++) cycle(1, 9'h023, 1, 0, 0, 0);
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_p1v", p1_evt_valid, 1);
        chk("ovf_p1k", p1_evt_key, 1);
        for (int i = 1; i <= 9; i++) begin
            cycle(0, 9'h000, 0, 0, 1, 0);
            chk($sformatf("drain%0d_p1v", i), p1_evt_valid, (i < 9) ? 1 : 0);
        end
        chk("drain_count", fifo_count, 0);
        chk("ovf_sticky", overflow, 1);

        // Head-of-line blocking: P2 waits behind the P1 head, order preserved.
        cycle(1, 9'h01C, 1, 0, 0, 1);
        cycle(1, 9'h16B, 1, 0, 0, 1);
        cycle(1, 9'h174, 1, 0, 0, 1);
        cycle(1, 9'h023, 1, 0, 0, 1);
        repeat (3) cycle(0, 9'h000, 0, 0, 0, 1);
        chk("hol_p1v", p1_evt_valid, 1);
        chk("hol_p2v", p2_evt_valid, 0);
        chk("hol_count", fifo_count, 3);
        deliv.delete();
        repeat (6) cycle(0, 9'h000, 0, 0, 1, 1);
        exp_order = '{0, 2, 3, 1};
        chk("order_len", deliv.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < deliv.size()) chk($sformatf("order%0d", i), deliv[i], exp_order[i]);

        // Freeze rising edge flushes queued and presented events.
        cycle(1, 9'h01C, 1, 0, 0, 0);
        cycle(1, 9'h174, 1, 0, 0, 0);
        cycle(1, 9'h023, 1, 0, 0, 0);
        cycle(0, 9'h000, 0, 0, 0, 0);
        chk("preflush_count", fifo_count, 2);
        cycle(0, 9'h000, 0, 1, 1, 1);
        chk("flush_count", fifo_count, 0);
        chk("flush_p1v", p1_evt_valid, 0);
        chk("flush_p2v", p2_evt_valid, 0);
        cycle(0, 9'h000, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a presentation.
        cycle(1, 9'h16B, 1, 0, 0, 0);
        cycle(1, 9'h01C, 1, 0, 0, 0);
        cycle(1, 9'h023, 1, 0, 0, 0);
        chk("pre_rst_p2v", p2_evt_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_p1v", p1_evt_valid, 0);
        chk("arst_p2v", p2_evt_valid, 0);
        chk("arst_p2k", p2_evt_key, 0);
        chk("arst_f", p1_foul | p2_foul, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_count", fifo_count, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic against the model.
        begin
            bit frz, kv, dn, r1, r2;
            logic [8:0] code;
            int rdy_pct;
            frz = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 29) == 0) frz = ~frz;
                rdy_pct = ((i / 300) % 2 == 0) ? 80 : 15;
                kv = ($urandom_range(0, 1) == 1);
                dn = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 5))
                    0:       code = 9'h01C;
                    1:       code = 9'h023;
                    2:       code = 9'h16B;
                    3:       code = 9'h174;
                    4:       code = 9'h029;
                    default: code = 9'($urandom());
                endcase
                r1 = ($urandom_range(0, 99) < rdy_pct);
                r2 = ($urandom_range(0, 99) < rdy_pct);
                cycle(kv, code, dn, frz, r1, r2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
